hazard_stall_ctrl: RTL and testbench

// - Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB); replaces the single-bit stop signal.
// - Emits per-stage stall (hold) and flush (bubble) vectors for three hazard sources: load-use, memory wait and taken branch.
// - Load-use stalls last LOAD_LAT cycles. A watchdog flags memory waits that exceed MAX_STALL cycles.

---
 rtl/hazard_stall_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central stall/flush controller for the 5-stage pipeline.
// Arbitrates load-use, memory-wait and taken-branch hazards into per-stage
// stall (hold) and flush (bubble) vectors, with a sticky memory-wait watchdog.
// Optional feature macro: STALL_PERF_CNT_EN builds a saturating 32-bit
// stall-cycle counter on perf_stall_cycles; otherwise that port is tied to 0.
module hazard_stall_ctrl #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned ID_STG     = 1,
    parameter int unsigned EX_STG     = 2,
    parameter int unsigned MEM_STG    = 3,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MAX_STALL  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_use_hazard,
    input  logic                  mem_busy,
    input  logic                  branch_taken,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  busy,
    output logic                  stall_timeout,
    output logic [31:0]           perf_stall_cycles
);

    localparam int unsigned LU_W = $clog2(LOAD_LAT + 1);
    localparam int unsigned WD_W = $clog2(MAX_STALL + 1);
    localparam int unsigned PERF_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [LU_W-1:0]     lu_cnt_q, lu_cnt_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic                ret_lu_q, ret_lu_d;
    logic                timeout_q, timeout_d;

    logic [NUM_STAGES-1:0] mem_stall_m, mem_flush_m;
    logic [NUM_STAGES-1:0] lu_stall_m, lu_flush_m;
    logic [NUM_STAGES-1:0] br_flush_m;
    logic [NUM_STAGES-1:0] stall_c, flush_c;
    logic                  eff_lu_c;

    // Constant per-hazard stage masks.
    always_comb begin
        mem_stall_m = '0;
        mem_flush_m = '0;
        lu_stall_m  = '0;
        lu_flush_m  = '0;
        br_flush_m  = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            mem_stall_m[i] = (i <= MEM_STG);
            mem_flush_m[i] = (i == MEM_STG + 1);
            lu_stall_m[i]  = (i <= ID_STG);
            lu_flush_m[i]  = (i == EX_STG);
            br_flush_m[i]  = (i >= ID_STG) && (i <= EX_STG) && (i != 0);
        end
    end

    // Leaving MEM_WAIT resumes the interrupted state in the same cycle.
    assign eff_lu_c = (state_q == LU_STALL) || ((state_q == MEM_WAIT) && ret_lu_q);

    // Hazard arbitration: mem_busy > branch_taken > load-use.
    always_comb begin
        stall_c  = '0;
        flush_c  = '0;
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        ret_lu_d = ret_lu_q;
        if (mem_busy) begin
            stall_c = mem_stall_m;
            flush_c = mem_flush_m;
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_lu_d = (state_q == LU_STALL);
            end
        end else if (branch_taken) begin
            flush_c  = br_flush_m;
            state_d  = IDLE;
            lu_cnt_d = '0;
            ret_lu_d = 1'b0;
        end else if (eff_lu_c) begin
            stall_c  = lu_stall_m;
            flush_c  = lu_flush_m;
            ret_lu_d = 1'b0;
            if (lu_cnt_q <= LU_W'(1)) begin
                state_d  = IDLE;
                lu_cnt_d = '0;
            end else begin
                state_d  = LU_STALL;
                lu_cnt_d = lu_cnt_q - LU_W'(1);
            end
        end else if (load_use_hazard) begin
            stall_c  = lu_stall_m;
            flush_c  = lu_flush_m;
            ret_lu_d = 1'b0;
            if (LOAD_LAT > 1) begin
                state_d  = LU_STALL;
                lu_cnt_d = LU_W'(LOAD_LAT - 1);
            end else begin
                state_d = IDLE;
            end
        end else begin
            state_d  = IDLE;
            ret_lu_d = 1'b0;
        end
    end

    // Watchdog: counts consecutive mem_busy cycles, saturating at MAX_STALL.
    always_comb begin
        wd_cnt_d  = '0;
        timeout_d = timeout_q;
        if (mem_busy) begin
            wd_cnt_d = (wd_cnt_q == WD_W'(MAX_STALL)) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
            if (wd_cnt_d == WD_W'(MAX_STALL)) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lu_cnt_q  <= '0;
            wd_cnt_q  <= '0;
            ret_lu_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lu_cnt_q  <= lu_cnt_d;
            wd_cnt_q  <= wd_cnt_d;
            ret_lu_q  <= ret_lu_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    // Saturating count of cycles with any stage stalled.
    always_comb begin
        perf_d = perf_q;
        if ((|stall_c) && (perf_q != {PERF_W{1'b1}})) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cycles = rst_n ? perf_q : '0;
`else
    assign perf_stall_cycles = PERF_W'(0);
`endif

    // All outputs are held at zero while reset is asserted.
    assign stall         = rst_n ? stall_c : '0;
    assign flush         = rst_n ? flush_c : '0;
    assign busy          = rst_n && (state_q != IDLE);
    assign stall_timeout = rst_n && timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: two instances (LOAD_LAT=1 and 3)
// share stimulus; a vector table covers reset, load-use, branch, and
// priority cases; hand-written loops cover the watchdog.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n, lu, mb, br;
    logic [4:0] s1, f1, s3, f3;
    logic b1, b3, t1, t3;
    logic [31:0] p1, p3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.LOAD_LAT(1), .MAX_STALL(15)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .load_use_hazard(lu), .mem_busy(mb),
        .branch_taken(br), .stall(s1), .flush(f1), .busy(b1),
        .stall_timeout(t1), .perf_stall_cycles(p1)
    );

    hazard_stall_ctrl #(.LOAD_LAT(3), .MAX_STALL(15)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .load_use_hazard(lu), .mem_busy(mb),
        .branch_taken(br), .stall(s3), .flush(f3), .busy(b3),
        .stall_timeout(t3), .perf_stall_cycles(p3)
    );

    typedef struct {
        logic       rst_n, lu, mb, br;
        logic [4:0] s1, f1;
        logic       b1;
        logic [4:0] s3, f3;
        logic       b3, to, pchk;
        int         p1, p3;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic l, input logic m, input logic b);
        @(posedge clk);
        #1;
        rst_n = r; lu = l; mb = m; br = b;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; lu = 1'b1; mb = 1'b1; br = 1'b1;

        //           rst lu mb br  s1       f1       b1  s3       f3       b3 to pchk p1 p3
        vecs[0]  = '{0, 1, 1, 1, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 1, 1, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1, 0, 0};
        vecs[3]  = '{1, 1, 0, 0, 5'b00011, 5'b00100, 0, 5'b00011, 5'b00100, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 5'b00000, 5'b00000, 0, 5'b00011, 5'b00100, 1, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 5'b00000, 5'b00000, 0, 5'b00011, 5'b00100, 1, 0, 0, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 1, 1, 3};
        vecs[7]  = '{1, 1, 0, 0, 5'b00011, 5'b00100, 0, 5'b00011, 5'b00100, 0, 0, 0, 0, 0};
        vecs[8]  = '{1, 0, 0, 1, 5'b00000, 5'b00110, 0, 5'b00000, 5'b00110, 1, 0, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 1, 0, 0, 5'b00011, 5'b00100, 0, 5'b00011, 5'b00100, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 0, 1, 0, 5'b01111, 5'b10000, 0, 5'b01111, 5'b10000, 1, 0, 0, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 5'b00000, 5'b00000, 1, 5'b00011, 5'b00100, 1, 0, 0, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 5'b00000, 5'b00000, 0, 5'b00011, 5'b00100, 1, 0, 0, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0};
        vecs[15] = '{1, 1, 1, 1, 5'b01111, 5'b10000, 0, 5'b01111, 5'b10000, 0, 0, 0, 0, 0};
        vecs[16] = '{1, 0, 0, 1, 5'b00000, 5'b00110, 1, 5'b00000, 5'b00110, 1, 0, 0, 0, 0};
        vecs[17] = '{1, 1, 0, 1, 5'b00000, 5'b00110, 0, 5'b00000, 5'b00110, 0, 0, 0, 0, 0};
        vecs[18] = '{1, 0, 0, 0, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0};

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].rst_n, vecs[i].lu, vecs[i].mb, vecs[i].br);
            check("stall_l1", i, 32'(s1), 32'(vecs[i].s1));
            check("flush_l1", i, 32'(f1), 32'(vecs[i].f1));
            check("busy_l1",  i, 32'(b1), 32'(vecs[i].b1));
            check("stall_l3", i, 32'(s3), 32'(vecs[i].s3));
            check("flush_l3", i, 32'(f3), 32'(vecs[i].f3));
            check("busy_l3",  i, 32'(b3), 32'(vecs[i].b3));
            check("tmo_l1",   i, 32'(t1), 32'(vecs[i].to));
            check("tmo_l3",   i, 32'(t3), 32'(vecs[i].to));
            if (vecs[i].pchk) begin
`ifdef STALL_PERF_CNT_EN
                check("perf_l1", i, p1, 32'(vecs[i].p1));
                check("perf_l3", i, p3, 32'(vecs[i].p3));
`else
                check("perf_l1", i, p1, 32'd0);
                check("perf_l3", i, p3, 32'd0);
`endif
            end
        end

        // Memory wait of 20 cycles: timeout becomes visible after the 15th.
        for (int k = 1; k <= 20; k++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0);
            check("mw_stall", k, 32'(s3), 32'h0F);
            check("mw_flush", k, 32'(f3), 32'h10);
            check("mw_tmo",   k, 32'(t3), 32'(k >= 16));
            check("mw_tmo_l1", k, 32'(t1), 32'(k >= 16));
        end

        // Timeout stays set after mem_busy drops.
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_busy", 1, 32'(b3), 32'd1);
        check("post_tmo",  1, 32'(t3), 32'd1);
        check("post_stall", 1, 32'(s3), 32'd0);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_busy", 2, 32'(b3), 32'd0);
        check("post_tmo",  2, 32'(t3), 32'd1);

        // Reset clears the sticky timeout.
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_tmo", 0, 32'(t3), 32'd0);
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        check("rel_tmo", 0, 32'(t3), 32'd0);
        check("rel_busy", 0, 32'(b3), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
